// File: rtl/ppm16_mod_pkg.sv
// Shared types and constants for the 16-PPM transmitter.
// PPM16_MOD_GRAY_EN selects Gray-coded header/data nibbles.
package ppm16_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        HDR  = 2'd2,
        DATA = 2'd3
    } ppm_state_e;

    localparam int PPM_CHIPS_PER_SYMBOL = 16;
    localparam int PPM_SYMBOL_BITS      = 4;
    localparam int LEN_BITS             = 8;

    localparam logic [PPM_SYMBOL_BITS-1:0] PRE_SYM_EVEN = 4'h0;
    localparam logic [PPM_SYMBOL_BITS-1:0] PRE_SYM_ODD  = 4'hF;

    // Nibble to pulse-position mapping; the preamble bypasses this.
    function automatic logic [PPM_SYMBOL_BITS-1:0] ppm_encode(input logic [PPM_SYMBOL_BITS-1:0] s);
`ifdef PPM16_MOD_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

endpackage

// File: rtl/ppm16_mod_if.sv
// Packet-request, symbol-stream and chip-output signals of the 16-PPM transmitter.
interface ppm16_mod_if;
    import ppm16_pkg::*;

    logic                       tx_start;
    logic [LEN_BITS-1:0]        tx_len;
    logic                       din_valid;
    logic [PPM_SYMBOL_BITS-1:0] din;
    logic                       din_ready;
    logic                       dout;
    logic                       tx_busy;
    logic                       tx_done;
    logic                       underrun;

    modport master (
        output tx_start, tx_len, din_valid, din,
        input  din_ready, dout, tx_busy, tx_done, underrun
    );

    modport slave (
        input  tx_start, tx_len, din_valid, din,
        output din_ready, dout, tx_busy, tx_done, underrun
    );

endinterface

// File: rtl/ppm16_mod_chip_timer.sv
// Sample-within-chip and chip-within-symbol counters for the 16-PPM transmitter.
module ppm16_chip_timer
    import ppm16_pkg::*;
#(
    parameter int CHIP_BITS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    output logic [3:0] chip_cnt_o,
    output logic       last_sample_of_chip_o,
    output logic       symbol_boundary_o
);

    localparam int SW = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(CHIP_BITS - 1);
    localparam logic [3:0]    CHIP_LAST   = 4'(PPM_CHIPS_PER_SYMBOL - 1);

    logic [SW-1:0] sample_cnt_q, sample_cnt_d;
    logic [3:0]    chip_cnt_q, chip_cnt_d;

    assign last_sample_of_chip_o = (sample_cnt_q == SAMPLE_LAST);
    assign symbol_boundary_o     = last_sample_of_chip_o && (chip_cnt_q == CHIP_LAST);
    assign chip_cnt_o            = chip_cnt_q;

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        chip_cnt_d   = chip_cnt_q;
        if (clear_i) begin
            sample_cnt_d = '0;
            chip_cnt_d   = '0;
        end else if (en_i) begin
            if (last_sample_of_chip_o) begin
                sample_cnt_d = '0;
                chip_cnt_d   = chip_cnt_q + 4'd1;
            end else begin
                sample_cnt_d = sample_cnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_cnt_q <= '0;
            chip_cnt_q   <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            chip_cnt_q   <= chip_cnt_d;
        end
    end

endmodule

// File: rtl/ppm16_mod.sv
// 16-PPM packet transmitter: preamble, 2-symbol length header, then data chips on dout.
// Define PPM16_MOD_GRAY_EN to Gray-code header/data nibbles before pulse mapping.
module ppm16_mod
    import ppm16_pkg::*;
#(
    parameter int CHIP_BITS        = 4,
    parameter int PREAMBLE_SYMBOLS = 8
) (
    input  logic         clk,
    input  logic         reset,
    ppm16_mod_if.slave   bus
);

    localparam logic [LEN_BITS-1:0] PRE_LAST = LEN_BITS'(PREAMBLE_SYMBOLS - 1);

    ppm_state_e                 state_q, state_d;
    logic [LEN_BITS-1:0]        sym_cnt_q, sym_cnt_d;
    logic [LEN_BITS-1:0]        len_q, len_d;
    logic [LEN_BITS-1:0]        acc_cnt_q, acc_cnt_d;
    logic [PPM_SYMBOL_BITS-1:0] cur_sym_q, cur_sym_d;
    logic                       cur_blank_q, cur_blank_d;
    logic [PPM_SYMBOL_BITS-1:0] hold_q, hold_d;
    logic                       hold_full_q, hold_full_d;
    logic                       dout_q, dout_d;
    logic                       done_q, done_d;
    logic                       underrun_q, underrun_d;

    logic       start, busy, din_ready, xfer;
    logic       take_data, finish;
    logic [3:0] chip_cnt, chip_nxt;
    logic       last_sample, boundary;

    assign busy      = (state_q != IDLE);
    assign start     = (state_q == IDLE) && bus.tx_start;
    assign din_ready = !hold_full_q && busy && (acc_cnt_q < len_q);
    assign xfer      = bus.din_valid && din_ready;
    assign chip_nxt  = last_sample ? chip_cnt + 4'd1 : chip_cnt;

    ppm16_chip_timer #(
        .CHIP_BITS (CHIP_BITS)
    ) u_timer (
        .clk                   (clk),
        .reset                 (reset),
        .clear_i               (start),
        .en_i                  (busy),
        .chip_cnt_o            (chip_cnt),
        .last_sample_of_chip_o (last_sample),
        .symbol_boundary_o     (boundary)
    );

    // Registers track the sample currently on dout; _d computes the next one.
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        len_d       = len_q;
        acc_cnt_d   = acc_cnt_q;
        cur_sym_d   = cur_sym_q;
        cur_blank_d = cur_blank_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        dout_d      = 1'b0;
        take_data   = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_d     = PRE;
                    sym_cnt_d   = '0;
                    len_d       = bus.tx_len;
                    acc_cnt_d   = '0;
                    cur_sym_d   = PRE_SYM_EVEN;
                    cur_blank_d = 1'b0;
                    hold_full_d = 1'b0;
                    underrun_d  = 1'b0;
                end
            end
            PRE: begin
                if (boundary) begin
                    if (sym_cnt_q == PRE_LAST) begin
                        state_d   = HDR;
                        sym_cnt_d = '0;
                        cur_sym_d = ppm_encode(len_q[7:4]);
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                        cur_sym_d = sym_cnt_q[0] ? PRE_SYM_EVEN : PRE_SYM_ODD;
                    end
                end
            end
            HDR: begin
                if (boundary) begin
                    if (sym_cnt_q == '0) begin
                        sym_cnt_d = 8'd1;
                        cur_sym_d = ppm_encode(len_q[3:0]);
                    end else if (len_q == '0) begin
                        finish = 1'b1;
                    end else begin
                        state_d   = DATA;
                        sym_cnt_d = '0;
                        take_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (boundary) begin
                    if (sym_cnt_q == len_q - 8'd1) begin
                        finish = 1'b1;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 8'd1;
                        take_data = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An empty holding register at a data boundary yields a blank symbol.
        if (take_data) begin
            if (hold_full_q) begin
                cur_sym_d   = ppm_encode(hold_q);
                cur_blank_d = 1'b0;
                hold_full_d = 1'b0;
            end else begin
                cur_blank_d = 1'b1;
                underrun_d  = 1'b1;
            end
        end

        if (finish) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end

        if (start) begin
            dout_d = (PRE_SYM_EVEN == 4'd0);
        end else if (busy && !finish) begin
            if (boundary) dout_d = !cur_blank_d && (cur_sym_d == 4'd0);
            else          dout_d = !cur_blank_q && (cur_sym_q == chip_nxt);
        end

        if (xfer) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
            acc_cnt_d   = acc_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sym_cnt_q   <= '0;
            len_q       <= '0;
            acc_cnt_q   <= '0;
            cur_sym_q   <= '0;
            cur_blank_q <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            dout_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            len_q       <= len_d;
            acc_cnt_q   <= acc_cnt_d;
            cur_sym_q   <= cur_sym_d;
            cur_blank_q <= cur_blank_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign bus.din_ready = din_ready;
    assign bus.dout      = dout_q;
    assign bus.tx_busy   = busy;
    assign bus.tx_done   = done_q;
    assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_ppm16_mod.sv
// Directed bench for ppm16_mod: packet traces, handshake, underrun, reset abort, back-to-back.
module tb_ppm16_mod;

    localparam int CB  = 4;
    localparam int PRE = 8;
    localparam int SYM = 16 * CB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ppm16_mod_if bus();

    ppm16_mod #(
        .CHIP_BITS        (CB),
        .PREAMBLE_SYMBOLS (PRE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic       trace [4096];
    logic       urun  [4096];
    logic [3:0] dq    [32];
    int         done_at;
    int         busy_cyc;
    bit         rdy_seen;

    function automatic logic [3:0] enc(input logic [3:0] s);
`ifdef PPM16_MOD_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    // Reference chip stream built from the packet format, compared against the capture.
    function automatic int mism(input int len, input bit blank_data);
        int n;
        n = 0;
        for (int s = 0; s < PRE + 2 + len; s++) begin
            logic [3:0] sym;
            logic [7:0] l8;
            bit blk;
            l8  = 8'(len);
            blk = 1'b0;
            if (s < PRE)           sym = (s % 2 == 1) ? 4'hF : 4'h0;
            else if (s == PRE)     sym = enc(l8[7:4]);
            else if (s == PRE + 1) sym = enc(l8[3:0]);
            else begin
                sym = enc(dq[s - PRE - 2]);
                blk = blank_data;
            end
            for (int k = 0; k < SYM; k++) begin
                logic e;
                e = !blk && ((k / CB) == int'(sym));
                if (trace[s * SYM + k] !== e) n++;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input logic [7:0] len);
        bus.tx_start = 1'b1;
        bus.tx_len   = len;
        @(negedge clk);
    endtask

    // Called at the negedge of the first busy cycle; returns at the tx_done cycle or stop_at.
    task automatic run_packet(input int ndata, input int pulse_at, input int stop_at);
        int idx;
        idx      = 0;
        done_at  = -1;
        busy_cyc = 0;
        rdy_seen = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            trace[c] = bus.dout;
            urun[c]  = bus.underrun;
            if (bus.tx_busy)   busy_cyc++;
            if (bus.din_ready) rdy_seen = 1'b1;
            if (bus.tx_done) begin
                done_at = c;
                break;
            end
            if (c == stop_at) break;
            bus.tx_start = (c == pulse_at);
            if (idx < ndata) begin
                bus.din_valid = 1'b1;
                bus.din       = dq[idx];
            end else begin
                bus.din_valid = 1'b0;
            end
            if (bus.din_valid && bus.din_ready) idx++;
            @(negedge clk);
        end
        bus.din_valid = 1'b0;
        bus.tx_start  = 1'b0;
    endtask

    initial begin
        int seen_done;
        bus.tx_start  = 1'b0;
        bus.tx_len    = 8'h00;
        bus.din_valid = 1'b0;
        bus.din       = 4'h0;
        reset         = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_dout",      int'(bus.dout),      0);
        chk("rst_busy",      int'(bus.tx_busy),   0);
        chk("rst_done",      int'(bus.tx_done),   0);
        chk("rst_underrun",  int'(bus.underrun),  0);
        chk("rst_din_ready", int'(bus.din_ready), 0);
        reset = 1'b0;
        @(negedge clk);

        // len=3 with data prefilled
        dq[0] = 4'h5; dq[1] = 4'hA; dq[2] = 4'h3;
        start_pkt(8'd3);
        run_packet(3, -1, -1);
        chk("a_done_at",  done_at,  832);
        chk("a_busy",     busy_cyc, 832);
        chk("a_trace",    mism(3, 1'b0), 0);
        chk("a_first",    int'(trace[0]), 1);
`ifndef PPM16_MOD_GRAY_EN
        chk("a_hdr0_512", int'(trace[512]), 1);
        chk("a_hdr0_516", int'(trace[516]), 0);
        chk("a_hdr1_588", int'(trace[588]), 1);
        chk("a_d0_660",   int'(trace[660]), 1);
        chk("a_d0_659",   int'(trace[659]), 0);
        chk("a_d1_747",   int'(trace[747]), 1);
        chk("a_d2_780",   int'(trace[780]), 1);
`endif
        chk("a_underrun", int'(bus.underrun), 0);
        chk("a_busy_low", int'(bus.tx_busy),  0);
        @(negedge clk);

        // len=0: header only, no data requested
        start_pkt(8'd0);
        run_packet(0, -1, -1);
        chk("b_done_at", done_at,  640);
        chk("b_busy",    busy_cyc, 640);
        chk("b_ready",   int'(rdy_seen), 0);
        chk("b_trace",   mism(0, 1'b0), 0);
        @(negedge clk);

        // len=2 starved: blank symbols and sticky underrun
        start_pkt(8'd2);
        run_packet(0, -1, -1);
        chk("c_done_at", done_at, 768);
        chk("c_urun639", int'(urun[639]), 0);
        chk("c_urun641", int'(urun[641]), 1);
        chk("c_trace",   mism(2, 1'b1), 0);
        chk("c_urun_end", int'(bus.underrun), 1);
        @(negedge clk);
        chk("c_urun_idle", int'(bus.underrun), 1);

        // new start clears underrun; tx_start mid-packet ignored
        start_pkt(8'd0);
        bus.tx_len = 8'h05;
        run_packet(0, 100, -1);
        chk("d_urun_clr", int'(urun[0]), 0);
        chk("d_done_at",  done_at, 640);
        chk("d_trace",    mism(0, 1'b0), 0);

        // back-to-back start in the tx_done cycle
        dq[0] = 4'hC;
        start_pkt(8'd1);
        run_packet(1, -1, -1);
        chk("e_b2b_busy0", int'(trace[0]), 1);
        chk("e_done_at",   done_at, 704);
        chk("e_busy",      busy_cyc, 704);
        chk("e_trace",     mism(1, 1'b0), 0);
        @(negedge clk);

        // reset mid-packet aborts without tx_done
        dq[0] = 4'h5; dq[1] = 4'hA; dq[2] = 4'h3;
        start_pkt(8'd3);
        run_packet(3, -1, 300);
        chk("f_busy300", int'(bus.tx_busy), 1);
        reset         = 1'b1;
        bus.din_valid = 1'b0;
        @(negedge clk);
        chk("f_rst_dout",  int'(bus.dout),      0);
        chk("f_rst_busy",  int'(bus.tx_busy),   0);
        chk("f_rst_ready", int'(bus.din_ready), 0);
        chk("f_rst_done",  int'(bus.tx_done),   0);
        reset     = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.tx_done) seen_done++;
        end
        chk("f_no_done", seen_done, 0);

        dq[0] = 4'h9;
        start_pkt(8'd1);
        run_packet(1, -1, -1);
        chk("g_done_at", done_at, 704);
        chk("g_trace",   mism(1, 1'b0), 0);
        @(negedge clk);

`ifdef PPM16_MOD_GRAY_EN
        for (int i = 0; i < 32; i++) dq[i] = 4'h5;
        start_pkt(8'h12);
        run_packet(18, -1, -1);
        chk("h_done_at", done_at, 1792);
        chk("h_hdr_512", int'(trace[512]), 0);
        chk("h_hdr_516", int'(trace[516]), 1);
        chk("h_hdr_588", int'(trace[588]), 1);
        chk("h_d0_668",  int'(trace[668]), 1);
        chk("h_d0_671",  int'(trace[671]), 1);
        chk("h_d0_660",  int'(trace[660]), 0);
        chk("h_trace",   mism(18, 1'b0), 0);
        @(negedge clk);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppm16_mod.md
Name: ppm16_mod

Overview:
- 16-PPM packet transmitter; the transmit-side counterpart of ppm16_demod.
- Takes a data-symbol count and a stream of 4-bit data symbols over a valid/ready handshake.
- Emits a serial chip stream on dout: preamble, 2-symbol length header, then data.
- Each symbol is 16 chips. Each chip lasts CHIP_BITS clock cycles. Output drives the SPAD-link laser driver.

Parameters:
- CHIP_BITS, 4, clock cycles per chip; must match the demod's samples-per-chip; must be ≥1.
- PREAMBLE_SYMBOLS, 8, number of preamble symbols; must be ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tx_start  in  1  starts a packet; sampled only in IDLE
- tx_len  in  8  data symbol count, latched on an accepted tx_start; 0 is legal (header only)
- din_valid  in  1  data symbol valid
- din  in  4  data symbol
- din_ready  out  1  holding register can accept a symbol
- dout  out  1  chip-sample output, registered
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-cycle pulse at end of packet
- underrun  out  1  sticky; a data symbol was missing at its boundary

Behaviour:
- Reset values: dout=0, din_ready=0, tx_busy=0, tx_done=0, underrun=0. FSM goes to IDLE and all counters and the holding register clear.
- Reset mid-packet aborts the packet immediately, with no tx_done.
- FSM states: IDLE → PRE → HDR → DATA → IDLE.
  - DATA is skipped when tx_len=0.
  - tx_done pulses on the final exit to IDLE.
- Counters:
  - sample_cnt runs 0..CHIP_BITS-1.
  - chip_cnt runs 0..15.
  - sym_cnt is 8 bits.
  - A symbol boundary occurs when sample_cnt=CHIP_BITS-1 and chip_cnt=15.
- Symbol mapping: the current symbol s drives dout=1 exactly while chip_cnt==s (CHIP_BITS consecutive cycles). dout=0 in every other cycle.
- Start timing:
  - tx_start is accepted only in IDLE. If sampled at edge n, dout carries preamble symbol 0, chip 0, sample 0 in the cycle after edge n.
  - tx_busy rises in that same cycle.
  - tx_start while busy is ignored.
- Preamble: symbol i is 0x0 for even i and 0xF for odd i, for i = 0..PREAMBLE_SYMBOLS-1.
- Header: two symbols, tx_len[7:4] then tx_len[3:0].
- Data:
  - tx_len symbols, each loaded from the holding register at its symbol boundary.
  - If the holding register is empty at that boundary, send a blank symbol (all 16*CHIP_BITS samples 0) and set underrun. The blank still counts toward tx_len.
- Handshake:
  - din_ready = holding register empty & tx_busy & (accepted symbols < tx_len).
  - A transfer happens when din_valid & din_ready at a clock edge.
  - Accepted symbols are never dropped. A symbol accepted on the same edge a boundary consumes the register is taken into the now-empty register.
- Packet length: (PREAMBLE_SYMBOLS+2+tx_len)*16*CHIP_BITS cycles.
- End of packet:
  - tx_done=1 and tx_busy=0 in the first cycle after the last sample.
  - A new tx_start is accepted on that same edge.
  - underrun clears only on reset or an accepted tx_start.

Optional Feature:
- Macro: PPM16_MOD_GRAY_EN.
- Defined: the header and data nibbles are Gray-coded (g = s ^ (s>>1)) before pulse-position mapping. The preamble is unaffected.
- Undefined: binary mapping, with the pulse at chip s.
- The demod must be built with the matching setting.

Decomposition:
- Package ppm16_pkg holds:
  - the FSM state typedef (IDLE, PRE, HDR, DATA)
  - PPM_CHIPS_PER_SYMBOL=16
  - PPM_SYMBOL_BITS=4
  - the preamble even/odd symbol constants (0x0/0xF)
  - LEN_BITS=8
- Sub-module ppm16_chip_timer holds sample_cnt and chip_cnt. It outputs chip_cnt, last_sample_of_chip and symbol_boundary, plus a clear input.

Test Plan (CHIP_BITS=4, PREAMBLE_SYMBOLS=8, 64 cycles/symbol):
- tx_len=3, data 0x5,0xA,0x3 prefilled → 832 busy cycles. Header pulses at offsets 512–515 (0x0) and 588–591 (0x3). Data pulses at 660–663, 744–747, 780–783. tx_done at cycle 832. underrun=0.
- tx_len=0 → 640 cycles (preamble + header 0x0,0x0). din_ready never asserts.
- tx_len=2, din_valid held low → two all-zero data symbols, underrun=1 after the first data boundary, tx_done still at cycle 768. A following tx_start clears underrun.
- reset asserted at cycle 300 of a packet → next cycle dout=0, tx_busy=0, din_ready=0, no tx_done. A new tx_start transmits a clean packet from preamble symbol 0.
- tx_start pulsed at cycle 100 while busy → ignored, length unchanged. A tx_start on the tx_done edge → back-to-back packet with no idle gap.
- PPM16_MOD_GRAY_EN defined, data 0x5 → pulse at chip 7 (samples 28–31 of the symbol). The header with tx_len=0x12 → chips 1 and 3.
